switch_egress_rx: RTL
=====================

# switch_egress_rx

Receive-side endpoint for one output port of the 4-port switch. Samples the switch's per-port `valid_out`/`data_out` stream, unpacks each packet into source, target and data, and discards packets that are misrouted or malformed. Accepted packets are buffered in a small first-word-fall-through FIFO and drained by the host over a valid/ready handshake. Saturating statistics counters track delivered, misrouted and dropped packets. One instance sits on each switch output port.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: one-hot port address width, one bit per switch port.
- `DATA_WIDTH`, 8: payload width.
- `PACKET_WIDTH`, 2*ADDR_WIDTH+DATA_WIDTH (16): packet layout {source[15:12], target[11:8], data[7:0]}, source in the MSBs.
- `PORT_ID`, 4'b0001: one-hot address of the port this instance terminates.
- `FIFO_DEPTH`, 4: buffer entries, power of two, ≥2.
- `CNT_WIDTH`, 16: statistics counter width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous reset, active-high.
- `valid_out` in 1: packet-valid strobe from the switch output port.
- `data_out` in PACKET_WIDTH: packet from the switch output port.
- `rx_valid` out 1: FIFO head is valid.
- `rx_ready` in 1: host accepts the head this cycle.
- `rx_source` out ADDR_WIDTH: head source field.
- `rx_target` out ADDR_WIDTH: head target field.
- `rx_data` out DATA_WIDTH: head payload.
- `occupancy` out $clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- `clear_stats` in 1: synchronous clear of the counters and `overflow`.
- `pkt_count` out CNT_WIDTH: packets enqueued.
- `misroute_count` out CNT_WIDTH: packets with target ≠ PORT_ID.
- `malformed_count` out CNT_WIDTH: packets whose source is not one-hot, or whose source equals the target.
- `drop_count` out CNT_WIDTH: valid packets lost because the FIFO was full.
- `overflow` out 1: sticky flag, set on any drop.

## Operation
- The switch has no backpressure, so every cycle with `valid_out`=1 is a packet that must be classified in that same cycle. Classification priority:
  1. Malformed: source is not exactly one-hot, or source == target. `malformed_count`++; the packet is discarded.
  2. Misroute: target ≠ PORT_ID. `misroute_count`++; the packet is discarded.
  3. Otherwise valid: enqueue if the FIFO has space, or if it is full and a pop happens in the same cycle. In either case `pkt_count`++.
  4. Otherwise (full and no pop): `drop_count`++, `overflow` is set, and the packet is discarded.
- Exactly one counter increments per `valid_out` cycle.
- Pop occurs when `rx_valid` && `rx_ready`. `rx_ready` has no effect when the FIFO is empty.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH, plus an occupancy counter. `rx_valid` = (occupancy ≠ 0). The `rx_*` fields are driven directly from the head entry and hold stable while `rx_valid`=1 and `rx_ready`=0.
- Simultaneous push and pop: occupancy is unchanged. This holds in both the full and the non-empty cases.
- Counters saturate at all-ones and never wrap.
- `clear_stats` zeroes all four counters and `overflow` on the next edge. It takes priority over an increment in the same cycle. It does not affect FIFO contents.
- `data_out` is ignored when `valid_out`=0.

## Timing
- Reset (async assert, released synchronously by the environment) forces:
  - `rx_valid`=0, `occupancy`=0, pointers=0;
  - all counters=0, `overflow`=0;
  - `rx_source`/`rx_target`/`rx_data`=0.
- A mid-operation reset discards all buffered packets immediately, without waiting for a clock edge.
- Latency: a packet sampled at edge N has `rx_valid`=1 and its fields on `rx_*` after edge N, i.e. one cycle. Counter updates are visible after the same edge.
- Throughput: one push and one pop per cycle, sustained.
- All state updates occur on the rising edge of `clk`. There is no combinational path from `valid_out`/`data_out` to any output.

## Test plan
- Reset, then one packet {0010,0001,8'hA5} with `rx_ready`=0. Required: after one edge, `rx_valid`=1, `rx_source`=0010, `rx_data`=A5, `occupancy`=1, `pkt_count`=1. The outputs hold over 3 idle cycles, and the entry is popped on the first `rx_ready`=1 cycle.
- Target 0100 at PORT_ID 0001. Required: `misroute_count`=1, FIFO stays empty. Source 0011 or 0000 → `malformed_count` increments. Source 0001 with target 0001 → `malformed_count` increments.
- Six back-to-back valid packets with `rx_ready`=0. Required: `occupancy`=4, `pkt_count`=4, `drop_count`=2, `overflow`=1. Draining then returns packets 1–4 in order.
- FIFO full, with `valid_out`=1 and `rx_ready`=1 in the same cycle. Required: no drop, `occupancy` stays 4, the new packet lands at the tail.
- Pointer wrap: 10 packets streamed with `rx_ready`=1 continuously. Required: all 10 are received in order and `occupancy` never exceeds 1.
- Preload `pkt_count` to all-ones, then one more packet. Required: the count stays all-ones. `clear_stats` pulsed together with a valid packet → all counters read 0 next cycle. Assert `rst` mid-stream with 3 entries queued → `rx_valid`=0 immediately.

Source files
------------

// File: rtl/switch_egress_rx_if.sv
// rtl/switch_egress_rx_if.sv - switch output stream and host receive handshake bundle
interface switch_egress_rx_if #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int PACKET_WIDTH = 2 * ADDR_WIDTH + DATA_WIDTH
);
  logic                    valid_out;
  logic [PACKET_WIDTH-1:0] data_out;
  logic                    rx_valid;
  logic                    rx_ready;
  logic [ADDR_WIDTH-1:0]   rx_source;
  logic [ADDR_WIDTH-1:0]   rx_target;
  logic [DATA_WIDTH-1:0]   rx_data;

  // Environment side: the switch port drives packets, the host drives ready.
  modport master (
    output valid_out, data_out, rx_ready,
    input  rx_valid, rx_source, rx_target, rx_data
  );

  // Endpoint side: the receive block.
  modport slave (
    input  valid_out, data_out, rx_ready,
    output rx_valid, rx_source, rx_target, rx_data
  );
endinterface

// File: rtl/switch_egress_rx.sv
// rtl/switch_egress_rx.sv - egress receive endpoint: classify, buffer and count switch packets
module switch_egress_rx #(
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    PACKET_WIDTH = 2 * ADDR_WIDTH + DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] PORT_ID      = ADDR_WIDTH'(1),
  parameter int                    FIFO_DEPTH   = 4,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  switch_egress_rx_if.slave            bus,
  output logic [$clog2(FIFO_DEPTH):0]  occupancy,
  input  logic                         clear_stats,
  output logic [CNT_WIDTH-1:0]         pkt_count,
  output logic [CNT_WIDTH-1:0]         misroute_count,
  output logic [CNT_WIDTH-1:0]         malformed_count,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PACKET_WIDTH-1:0] head;

  logic [ADDR_WIDTH-1:0]   in_source;
  logic [ADDR_WIDTH-1:0]   in_target;
  logic                    source_one_hot;
  logic                    is_malformed;
  logic                    is_misroute;
  logic                    is_good;
  logic                    fifo_full;
  logic                    rx_valid_i;
  logic                    pop;
  logic                    push;
  logic                    drop;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Classify the incoming packet and decide push/pop/drop for this cycle.
  always_comb begin
    in_source      = bus.data_out[PACKET_WIDTH-1 -: ADDR_WIDTH];
    in_target      = bus.data_out[DATA_WIDTH +: ADDR_WIDTH];
    source_one_hot = (in_source != '0) &&
                     ((in_source & (in_source - ADDR_WIDTH'(1))) == '0);
    is_malformed   = !source_one_hot || (in_source == in_target);
    is_misroute    = !is_malformed && (in_target != PORT_ID);
    is_good        = !is_malformed && !is_misroute;
    fifo_full      = (occupancy == OCC_W'(FIFO_DEPTH));
    rx_valid_i     = (occupancy != '0);
    pop            = rx_valid_i && bus.rx_ready;
    // A full FIFO still accepts a packet when the head leaves in the same cycle.
    push           = bus.valid_out && is_good && (!fifo_full || pop);
    drop           = bus.valid_out && is_good && fifo_full && !pop;
  end

  // Head entry is presented directly; forced to zero when empty so reset clears the fields.
  always_comb begin
    head          = mem[rd_ptr];
    bus.rx_valid  = rx_valid_i;
    bus.rx_source = rx_valid_i ? head[PACKET_WIDTH-1 -: ADDR_WIDTH] : '0;
    bus.rx_target = rx_valid_i ? head[DATA_WIDTH +: ADDR_WIDTH]     : '0;
    bus.rx_data   = rx_valid_i ? head[DATA_WIDTH-1:0]               : '0;
  end

  // Storage array write; contents need no reset since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_out;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Saturating statistics; a clear request wins over any increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count       <= '0;
      misroute_count  <= '0;
      malformed_count <= '0;
      drop_count      <= '0;
      overflow        <= 1'b0;
    end else if (clear_stats) begin
      pkt_count       <= '0;
      misroute_count  <= '0;
      malformed_count <= '0;
      drop_count      <= '0;
      overflow        <= 1'b0;
    end else if (bus.valid_out) begin
      if (is_malformed) malformed_count <= sat_inc(malformed_count);
      if (is_misroute)  misroute_count  <= sat_inc(misroute_count);
      if (push)         pkt_count       <= sat_inc(pkt_count);
      if (drop) begin
        drop_count <= sat_inc(drop_count);
        overflow   <= 1'b1;
      end
    end
  end

endmodule
